// File: rtl/stopwatch_counter.sv
// Purpose : clock-divided mm:ss.cc stopwatch core with IDLE/RUN/PAUSE control, six BCD digit outputs.
// Latency : commands take effect on the edge that samples them; first count DIV cycles after entering RUN.
// Backpr. : none; command pulses are consumed every cycle, outputs are always valid.
//
// Ports:
//   clk, reset            : system clock, synchronous active-high reset (dominates everything)
//   start_stop, clear     : single-cycle command pulses (start/pause/resume, zero when not running)
//   lap                   : single-cycle lap pulse, only when STOPWATCH_LAP_HOLD_EN is defined
//   cs_units..min_tens    : BCD digits of mm:ss.cc, one per downstream segment decoder
//   running               : high while in RUN
//   wrap                  : one-cycle pulse after rolling over 59:59.99 -> 00:00.00
//
// Optional feature macro: STOPWATCH_LAP_HOLD_EN (lap freeze of the displayed digits).

module stopwatch_counter #(
    parameter int CLK_HZ  = 50000000,
    parameter int TICK_HZ = 100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_HOLD_EN
    input  logic       lap,
`endif
    output logic [3:0] cs_units,
    output logic [3:0] cs_tens,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       wrap
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_pre;
    logic [PW-1:0] w_pre_nxt;

    logic [3:0] r_cs_u, r_cs_t, r_sec_u, r_sec_t, r_min_u, r_min_t;
    logic [3:0] w_cs_u_nxt, w_cs_t_nxt, w_sec_u_nxt, w_sec_t_nxt, w_min_u_nxt, w_min_t_nxt;
    logic       r_running;
    logic       r_wrap;

    logic       w_zero;      // clear accepted: zero digits and prescaler
    logic       w_advance;   // prescaler may move this edge
    logic       w_tick;      // count increments this edge
    logic       w_c1, w_c2, w_c3, w_c4, w_c5, w_c6;  // carry into each digit / out of the top
    logic [23:0] w_live;
    logic [23:0] w_shown;

    // Control FSM: next state and clear acceptance
    always_comb begin
        w_state_nxt = r_state;
        w_zero      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_zero = 1'b1;
                end else if (start_stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // clear is ignored while running, even alongside start_stop
                if (start_stop) begin
                    w_state_nxt = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (clear) begin
                    w_state_nxt = S_IDLE;
                    w_zero      = 1'b1;
                end else if (start_stop) begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_zero      = 1'b1;
            end
        endcase
    end

    // The edge that leaves RUN neither advances the prescaler nor counts, so a
    // pause landing on a tick edge swallows nothing and resume keeps the phase.
    always_comb begin
        w_advance = (r_state == S_RUN) && !start_stop;
        w_tick    = w_advance && (r_pre == PRE_MAX);
        w_pre_nxt = r_pre;
        if (w_zero || w_tick) begin
            w_pre_nxt = '0;
        end else if (w_advance) begin
            w_pre_nxt = r_pre + PW'(1);
        end
    end

    // Ripple BCD chain: each digit wraps at its max and passes a carry upward
    always_comb begin
        w_c1 = w_tick && (r_cs_u  == 4'd9);
        w_c2 = w_c1   && (r_cs_t  == 4'd9);
        w_c3 = w_c2   && (r_sec_u == 4'd9);
        w_c4 = w_c3   && (r_sec_t == 4'd5);
        w_c5 = w_c4   && (r_min_u == 4'd9);
        w_c6 = w_c5   && (r_min_t == 4'd5);

        w_cs_u_nxt  = r_cs_u;
        w_cs_t_nxt  = r_cs_t;
        w_sec_u_nxt = r_sec_u;
        w_sec_t_nxt = r_sec_t;
        w_min_u_nxt = r_min_u;
        w_min_t_nxt = r_min_t;

        if (w_zero) begin
            w_cs_u_nxt  = 4'd0;
            w_cs_t_nxt  = 4'd0;
            w_sec_u_nxt = 4'd0;
            w_sec_t_nxt = 4'd0;
            w_min_u_nxt = 4'd0;
            w_min_t_nxt = 4'd0;
        end else begin
            if (w_tick) w_cs_u_nxt  = w_c1 ? 4'd0 : r_cs_u  + 4'd1;
            if (w_c1)   w_cs_t_nxt  = w_c2 ? 4'd0 : r_cs_t  + 4'd1;
            if (w_c2)   w_sec_u_nxt = w_c3 ? 4'd0 : r_sec_u + 4'd1;
            if (w_c3)   w_sec_t_nxt = w_c4 ? 4'd0 : r_sec_t + 4'd1;
            if (w_c4)   w_min_u_nxt = w_c5 ? 4'd0 : r_min_u + 4'd1;
            if (w_c5)   w_min_t_nxt = w_c6 ? 4'd0 : r_min_t + 4'd1;
        end
    end

    // Digits are written every cycle (hold = rewrite of own value)
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_pre     <= '0;
            r_cs_u    <= 4'd0;
            r_cs_t    <= 4'd0;
            r_sec_u   <= 4'd0;
            r_sec_t   <= 4'd0;
            r_min_u   <= 4'd0;
            r_min_t   <= 4'd0;
            r_running <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pre     <= w_pre_nxt;
            r_cs_u    <= w_cs_u_nxt;
            r_cs_t    <= w_cs_t_nxt;
            r_sec_u   <= w_sec_u_nxt;
            r_sec_t   <= w_sec_t_nxt;
            r_min_u   <= w_min_u_nxt;
            r_min_t   <= w_min_t_nxt;
            r_running <= (w_state_nxt == S_RUN);
            r_wrap    <= w_c6;
        end
    end

    assign w_live = {r_min_t, r_min_u, r_sec_t, r_sec_u, r_cs_t, r_cs_u};

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        r_freeze;
    logic [23:0] r_disp;

    // First lap in RUN snapshots the live count, second lap releases it
    always_ff @(posedge clk) begin
        if (reset) begin
            r_freeze <= 1'b0;
            r_disp   <= 24'd0;
        end else if (w_zero) begin
            r_freeze <= 1'b0;
        end else if ((r_state == S_RUN) && lap) begin
            if (!r_freeze) begin
                r_disp   <= w_live;
                r_freeze <= 1'b1;
            end else begin
                r_freeze <= 1'b0;
            end
        end
    end

    assign w_shown = r_freeze ? r_disp : w_live;
`else
    assign w_shown = w_live;
`endif

    assign min_tens  = w_shown[23:20];
    assign min_units = w_shown[19:16];
    assign sec_tens  = w_shown[15:12];
    assign sec_units = w_shown[11:8];
    assign cs_tens   = w_shown[7:4];
    assign cs_units  = w_shown[3:0];
    assign running   = r_running;
    assign wrap      = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Purpose : self-checking bench for stopwatch_counter at DIV=10 against a count-level reference model.
// Latency : model is updated on each rising edge, outputs compared on the following falling edge.
// Backpr. : none.

module tb_stopwatch_counter;

    localparam int DIV   = 10;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int FULL  = 360000;   // centiseconds in one hour

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
`ifdef STOPWATCH_LAP_HOLD_EN
    logic       lap = 1'b0;
`endif
    logic [3:0] cs_units, cs_tens, sec_units, sec_tens, min_units, min_tens;
    logic       running, wrap;

    stopwatch_counter #(.CLK_HZ(10), .TICK_HZ(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_stop (start_stop),
        .clear      (clear),
`ifdef STOPWATCH_LAP_HOLD_EN
        .lap        (lap),
`endif
        .cs_units   (cs_units),
        .cs_tens    (cs_tens),
        .sec_units  (sec_units),
        .sec_tens   (sec_tens),
        .min_units  (min_units),
        .min_tens   (min_tens),
        .running    (running),
        .wrap       (wrap)
    );

    always #5 clk = ~clk;

    logic [23:0] obs;
    logic        legal;
    assign obs   = {min_tens, min_units, sec_tens, sec_units, cs_tens, cs_units};
    assign legal = (cs_units <= 4'd9) && (cs_tens <= 4'd9) && (sec_units <= 4'd9) &&
                   (sec_tens <= 4'd5) && (min_units <= 4'd9) && (min_tens <= 4'd5);

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: total centiseconds as a plain integer
    int   m_state = M_IDLE;
    int   m_pre   = 0;
    int   m_cnt   = 0;
    logic m_wrap  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic logic [23:0] exp_digits(input int c);
        logic [23:0] d;
        d[3:0]   = 4'(c % 10);
        d[7:4]   = 4'((c / 10) % 10);
        d[11:8]  = 4'((c / 100) % 10);
        d[15:12] = 4'((c / 1000) % 6);
        d[19:16] = 4'((c / 6000) % 10);
        d[23:20] = 4'(c / 60000);
        return d;
    endfunction

    task automatic model_step(input logic ss, input logic clr, input logic rst);
        m_wrap = 1'b0;
        if (rst) begin
            m_state = M_IDLE;
            m_pre   = 0;
            m_cnt   = 0;
        end else if (m_state == M_RUN) begin
            if (ss) begin
                m_state = M_PAUSE;
            end else if (m_pre == DIV - 1) begin
                m_pre  = 0;
                m_wrap = (m_cnt == FULL - 1);
                m_cnt  = (m_cnt + 1) % FULL;
            end else begin
                m_pre++;
            end
        end else if (clr) begin
            m_state = M_IDLE;
            m_pre   = 0;
            m_cnt   = 0;
        end else if (ss) begin
            m_state = M_RUN;
        end
    endtask

    // one clock: drive at negedge, model at posedge, compare at next negedge
    task automatic cycle(input logic ss, input logic clr, input logic rst);
        start_stop = ss;
        clear      = clr;
        reset      = rst;
        @(posedge clk);
        model_step(ss, clr, rst);
        @(negedge clk);
        start_stop = 1'b0;
        clear      = 1'b0;
        reset      = 1'b0;
        chk("digits", {8'd0, obs}, {8'd0, exp_digits(m_cnt)});
        chk("running", {31'd0, running}, {31'd0, m_state == M_RUN});
        chk("wrap", {31'd0, wrap}, {31'd0, m_wrap});
        chk("bcd_range", {31'd0, legal}, 32'd1);
    endtask

    initial begin
        int  n;
        bit  seen;

        @(negedge clk);
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
        chk("rst_running", {31'd0, running}, 32'd0);
        chk("rst_wrap", {31'd0, wrap}, 32'd0);
        chk("rst_digits", {8'd0, obs}, 32'd0);

        // start, first tick exactly DIV cycles after entering RUN
        cycle(1'b1, 1'b0, 1'b0);
        chk("start_running", {31'd0, running}, 32'd1);
        chk("start_digits", {8'd0, obs}, 32'd0);
        for (int i = 0; i < DIV - 1; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk("pre_first_tick", {8'd0, obs}, 32'd0);
        end
        cycle(1'b0, 1'b0, 1'b0);
        chk("first_tick", {28'd0, cs_units}, 32'd1);

        // 99 more ticks -> 00:01.00
        repeat (99 * DIV) cycle(1'b0, 1'b0, 1'b0);
        chk("one_second", {8'd0, obs}, 32'h000100);

        // pause 4 cycles into a tick, hold, resume: next count 6 cycles later
        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        chk("paused", {31'd0, running}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk("pause_hold", {8'd0, obs}, 32'h000100);
        end
        cycle(1'b1, 1'b0, 1'b0);
        chk("resumed", {31'd0, running}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            chk("resume_wait", {8'd0, obs}, 32'h000100);
        end
        cycle(1'b0, 1'b0, 1'b0);
        chk("resume_tick", {8'd0, obs}, 32'h000101);

        // clear in RUN is ignored; pause then clear goes to IDLE with zeros
        cycle(1'b0, 1'b1, 1'b0);
        chk("clear_in_run_running", {31'd0, running}, 32'd1);
        chk("clear_in_run_digits", {8'd0, obs}, 32'h000101);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("pause_clear_digits", {8'd0, obs}, 32'd0);
        chk("pause_clear_running", {31'd0, running}, 32'd0);

        // simultaneous start_stop+clear: RUN -> PAUSE keeps count, PAUSE -> IDLE zeros
        cycle(1'b1, 1'b0, 1'b0);
        repeat (37) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("ssclr_run_running", {31'd0, running}, 32'd0);
        chk("ssclr_run_digits", {8'd0, obs}, 32'h000003);
        cycle(1'b1, 1'b1, 1'b0);
        chk("ssclr_pause_digits", {8'd0, obs}, 32'd0);
        chk("ssclr_pause_running", {31'd0, running}, 32'd0);

        // preload 59:59.99 while paused 3 cycles into a tick, then resume into the wrap
        cycle(1'b1, 1'b0, 1'b0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        force dut.r_min_t = 4'd5;
        force dut.r_min_u = 4'd9;
        force dut.r_sec_t = 4'd5;
        force dut.r_sec_u = 4'd9;
        force dut.r_cs_t  = 4'd9;
        force dut.r_cs_u  = 4'd9;
        m_cnt = FULL - 1;
        cycle(1'b0, 1'b0, 1'b0);
        release dut.r_min_t;
        release dut.r_min_u;
        release dut.r_sec_t;
        release dut.r_sec_u;
        release dut.r_cs_t;
        release dut.r_cs_u;
        cycle(1'b0, 1'b0, 1'b0);
        chk("preload", {8'd0, obs}, 32'h595999);
        cycle(1'b1, 1'b0, 1'b0);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 2 * DIV) begin
            cycle(1'b0, 1'b0, 1'b0);
            n++;
            if (wrap) seen = 1'b1;
        end
        chk("wrap_latency", n, DIV - 3);
        chk("wrap_digits", {8'd0, obs}, 32'd0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("wrap_one_cycle", {31'd0, wrap}, 32'd0);
        chk("wrap_keeps_running", {31'd0, running}, 32'd1);

        // reset mid-RUN
        repeat (25) cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        chk("midrun_reset_digits", {8'd0, obs}, 32'd0);
        chk("midrun_reset_running", {31'd0, running}, 32'd0);

        // random command traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cycle($urandom_range(0, 15) == 0,
                  $urandom_range(0, 15) == 0,
                  $urandom_range(0, 299) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
- Timebase and BCD counting core of the VGA/7-segment stopwatch; sits directly upstream of the per-digit binary-to-segment decoders.
- Divides the system clock down to 1/100 s ticks and keeps an mm:ss.cc count as six 4-bit BCD digits. Each digit feeds one decoder's digit input.
- Run, pause and clear are controlled by single-cycle command pulses from the debounced button stage.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- TICK_HZ, 100, count rate in Hz. DIV = CLK_HZ/TICK_HZ; CLK_HZ must be an exact multiple of TICK_HZ and DIV must be ≥ 2.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start_stop  input  1  single-cycle pulse: start, pause or resume
- clear  input  1  single-cycle pulse: zero the count (ignored while running)
- cs_units  output  4  centiseconds units, BCD 0-9
- cs_tens  output  4  centiseconds tens, BCD 0-9
- sec_units  output  4  seconds units, BCD 0-9
- sec_tens  output  4  seconds tens, BCD 0-5
- min_units  output  4  minutes units, BCD 0-9
- min_tens  output  4  minutes tens, BCD 0-5
- running  output  1  high when state is RUN
- wrap  output  1  one-cycle pulse on rollover from 59:59.99 to 00:00.00
- lap  input  1  single-cycle lap pulse; present only with LAP_HOLD_EN

Behaviour:
- Reset is synchronous, active-high and dominates all other inputs:
  - state = IDLE; prescaler = 0.
  - All six digits = 0; running = 0; wrap = 0; freeze cleared.
- States are IDLE, RUN and PAUSE. running = (state == RUN), registered.
- Transitions on a start_stop pulse: IDLE→RUN, RUN→PAUSE, PAUSE→RUN.
- Transitions on a clear pulse:
  - IDLE or PAUSE → IDLE, with digits and prescaler zeroed on the same edge.
  - RUN: clear is ignored.
- Simultaneous start_stop and clear:
  - In RUN: go to PAUSE; clear is ignored.
  - In IDLE or PAUSE: clear wins and the state becomes IDLE.
- Prescaler width is ceil(log2(DIV)).
  - It counts only in RUN.
  - When it is DIV-1 in RUN: it loads 0 and the count increments on the same edge.
  - In PAUSE it holds its value, so resume keeps the partial tick.
  - It is zeroed on clear.
- The first increment after IDLE→RUN occurs exactly DIV cycles after the edge that entered RUN.
- Increment is a ripple BCD chain, all digits updated on one edge:
  - Each digit carries when at its max (9, or 5 for sec_tens and min_tens) and goes to 0.
  - The next digit increments only on carry.
  - Digits never hold a non-BCD value or exceed their max.
- At 59:59.99 an increment gives 00:00.00, and wrap = 1 for that one following cycle. Counting continues in RUN.
- The start_stop pulse that enters PAUSE on the edge where a tick would fire takes priority: no increment occurs.
- Outputs are registered. Digits are valid at all times, including in IDLE (all 0), so the downstream decoders can stay enabled.

Optional Feature:
- Macro: STOPWATCH_LAP_HOLD_EN.
- When defined:
  - The lap port exists.
  - A lap pulse in RUN captures the internal count into a display register and sets freeze. The digit outputs then show the captured value while internal counting continues.
  - A second lap pulse clears freeze, and the outputs track the live count from the next cycle.
  - lap in IDLE or PAUSE is ignored.
  - clear or reset also clears freeze.
  - wrap still follows the internal count.
- When undefined: there is no lap port and no display register; digit outputs are the live counter registers.

Test Plan:
- CLK_HZ=10, TICK_HZ=1 (DIV=10). Reset 2 cycles, then start_stop pulse → running=1 next cycle; digits all 0 for 10 cycles; cs_units=1 exactly 10 cycles after entering RUN.
- Run 100 ticks → digits read 00:01.00 (cs_tens=0, sec_units=1). Check the carry chain and that no digit is ever >9.
- Preload near the end by running or forcing to 59:59.99, then one tick → all digits 0 and wrap high for exactly 1 cycle.
- Pause 4 cycles into a tick, hold 20 cycles (digits frozen), resume → next increment 6 cycles after resume. Then clear while in RUN → no effect; pause + clear → IDLE with all zeros.
- Simultaneous start_stop+clear in RUN → PAUSE, count kept. In PAUSE → IDLE, count zeroed. Assert reset mid-RUN → all outputs 0 on the next edge.
- With STOPWATCH_LAP_HOLD_EN: lap at 00:00.05, run 10 ticks → outputs stay 00:00.05. Second lap → outputs show 00:00.15 next cycle.
